// File: rtl/motor_cmd_ramp.sv
// Slew-rate limiter and safety stage ahead of the H-bridge driver: clamps and ramps signed duty
// commands, forces a zero-duty dwell before any direction reversal, and zeroes on controller loss.
module motor_cmd_ramp #(
    parameter int unsigned NBits       = 9,
    parameter int unsigned MaxMag      = 2 ** (NBits - 1) - 1,
    parameter int unsigned Step        = 16,
    parameter int unsigned StepDiv     = 4,
    parameter int unsigned DwellCycles = 8,
    parameter int unsigned WdCycles    = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [NBits-1:0] cmd_i,
    input  logic             cmd_valid_i,
    output logic [NBits-1:0] pwm_o,
    output logic             settled_o,
    output logic             timeout_o
);

    localparam int unsigned PreW = (StepDiv > 1) ? $clog2(StepDiv) : 1;
    localparam int unsigned DwW  = (DwellCycles > 1) ? $clog2(DwellCycles) : 1;
    localparam int unsigned WdW  = (WdCycles > 1) ? $clog2(WdCycles) : 1;

    localparam logic [PreW-1:0] PreLast = PreW'(StepDiv - 1);
    localparam logic [DwW-1:0]  DwLoad  = DwW'(DwellCycles - 1);
    localparam logic [WdW-1:0]  WdLast  = WdW'((WdCycles > 0) ? WdCycles - 1 : 0);

    // One extra bit so differences between two in-range duties never wrap.
    typedef logic signed [NBits:0]   wide_t;
    typedef logic signed [NBits-1:0] duty_t;

    localparam wide_t MaxPos = wide_t'(MaxMag);
    localparam wide_t MaxNeg = -MaxPos;
    localparam wide_t StepW  = wide_t'(Step);

    typedef enum logic [0:0] {StRamp, StDwell} state_e;

    state_e          state_q, state_d;
    duty_t           pwm_q, pwm_d;
    duty_t           target_q, target_d;
    logic            settled_q, settled_d;
    logic            timeout_q, timeout_d;
    logic [PreW-1:0] pre_q, pre_d;
    logic [DwW-1:0]  dwell_q, dwell_d;
    logic [WdW-1:0]  wd_q, wd_d;

    logic  tick;
    logic  wd_expire;
    logic  reversing;
    logic  zero_reached;
    wide_t cmd_w;
    wide_t pwm_w;
    wide_t tgt_w;
    wide_t diff_w;
    wide_t diff_abs;
    wide_t pwm_abs;
    duty_t cmd_clamp;
    duty_t toward_tgt;
    duty_t toward_zero;

    // Symmetric saturation; the most negative code maps to -MaxMag.
    always_comb begin
        cmd_w = wide_t'($signed(cmd_i));
        if (cmd_w > MaxPos) begin
            cmd_clamp = duty_t'(MaxPos);
        end else if (cmd_w < MaxNeg) begin
            cmd_clamp = duty_t'(MaxNeg);
        end else begin
            cmd_clamp = duty_t'(cmd_w);
        end
    end

    always_comb begin
        wd_expire = 1'b0;
        wd_d      = wd_q;
        if (cmd_valid_i) begin
            wd_d = '0;
        end else if (WdCycles != 0) begin
            if (wd_q == WdLast) begin
                wd_expire = 1'b1;
            end else begin
                wd_d = wd_q + WdW'(1);
            end
        end
    end

    // A valid command in the expiry cycle takes precedence over the timeout.
    always_comb begin
        target_d  = target_q;
        timeout_d = timeout_q;
        if (cmd_valid_i) begin
            target_d  = cmd_clamp;
            timeout_d = 1'b0;
        end else if (wd_expire) begin
            target_d  = '0;
            timeout_d = 1'b1;
        end
    end

    always_comb begin
        pwm_w    = wide_t'(pwm_q);
        tgt_w    = wide_t'(target_q);
        diff_w   = tgt_w - pwm_w;
        diff_abs = diff_w[NBits] ? -diff_w : diff_w;
        pwm_abs  = pwm_w[NBits] ? -pwm_w : pwm_w;

        reversing = (pwm_q != '0) && (target_q != '0) &&
                    (pwm_q[NBits-1] != target_q[NBits-1]);

        if (diff_abs <= StepW) begin
            toward_tgt = target_q;
        end else if (diff_w[NBits]) begin
            toward_tgt = duty_t'(pwm_w - StepW);
        end else begin
            toward_tgt = duty_t'(pwm_w + StepW);
        end

        zero_reached = (pwm_abs <= StepW);
        if (zero_reached) begin
            toward_zero = '0;
        end else if (pwm_q[NBits-1]) begin
            toward_zero = duty_t'(pwm_w + StepW);
        end else begin
            toward_zero = duty_t'(pwm_w - StepW);
        end

        tick = (pre_q == PreLast);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRamp: begin
                if (tick && reversing && zero_reached) begin
                    state_d = StDwell;
                end
            end
            StDwell: begin
                if (dwell_q == '0) begin
                    state_d = StRamp;
                end
            end
            default: state_d = StRamp;
        endcase
    end

    // Leaving the dwell restarts the prescaler so the first step is a full tick period away.
    always_comb begin
        pwm_d   = pwm_q;
        dwell_d = dwell_q;
        pre_d   = tick ? '0 : pre_q + PreW'(1);
        unique case (state_q)
            StRamp: begin
                if (tick) begin
                    if (reversing) begin
                        pwm_d = toward_zero;
                        if (zero_reached) begin
                            dwell_d = DwLoad;
                        end
                    end else begin
                        pwm_d = toward_tgt;
                    end
                end
            end
            StDwell: begin
                pwm_d = '0;
                if (dwell_q == '0) begin
                    pre_d = '0;
                end else begin
                    dwell_d = dwell_q - DwW'(1);
                end
            end
            default: begin
                pwm_d = '0;
            end
        endcase
        settled_d = (pwm_d == target_d) && (state_d == StRamp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRamp;
            pwm_q     <= '0;
            target_q  <= '0;
            settled_q <= 1'b1;
            timeout_q <= 1'b0;
            pre_q     <= '0;
            dwell_q   <= '0;
            wd_q      <= '0;
        end else if (en) begin
            state_q   <= state_d;
            pwm_q     <= pwm_d;
            target_q  <= target_d;
            settled_q <= settled_d;
            timeout_q <= timeout_d;
            pre_q     <= pre_d;
            dwell_q   <= dwell_d;
            wd_q      <= wd_d;
        end
    end

    assign pwm_o     = pwm_q;
    assign settled_o = settled_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_motor_cmd_ramp.sv
// Bench for motor_cmd_ramp: fixed vector table, directed corner sequences and random traffic,
// all compared against a behavioural model of the ramp/dwell/watchdog rules.
module tb_motor_cmd_ramp;

    localparam int MAX   = 255;
    localparam int STEP  = 16;
    localparam int DIV   = 4;
    localparam int DWELL = 8;
    localparam int WD    = 1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [8:0] cmd_i;
    logic       cmd_valid_i;
    logic [8:0] pwm_o;
    logic       settled_o;
    logic       timeout_o;

    int n_cmp  = 0;
    int n_fail = 0;

    motor_cmd_ramp #(
        .NBits      (9),
        .MaxMag     (MAX),
        .Step       (STEP),
        .StepDiv    (DIV),
        .DwellCycles(DWELL),
        .WdCycles   (WD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cmd_i      (cmd_i),
        .cmd_valid_i(cmd_valid_i),
        .pwm_o      (pwm_o),
        .settled_o  (settled_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "time limit");
    end

    // Behavioural model: plain integers, time measured in enabled cycles.
    int m_pwm, m_tgt, m_dwell_left, m_phase, m_idle;
    bit m_to;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int sgn(input int x);
        return (x > 0) ? 1 : ((x < 0) ? -1 : 0);
    endfunction

    function automatic int clamp(input int x);
        if (x > MAX) return MAX;
        if (x < -MAX) return -MAX;
        return x;
    endfunction

    function automatic int sint(input logic [8:0] x);
        return int'($signed(x));
    endfunction

    task automatic model_reset();
        m_pwm = 0; m_tgt = 0; m_dwell_left = 0; m_phase = 0; m_idle = 0; m_to = 0;
    endtask

    task automatic model_step(input bit v, input int c);
        bit is_tick;
        is_tick = (m_phase == DIV - 1);
        if (m_dwell_left > 0) begin
            m_dwell_left--;
            m_phase = (m_dwell_left == 0) ? 0 : (m_phase + 1) % DIV;
        end else begin
            if (is_tick) begin
                if (m_pwm != 0 && m_tgt != 0 && sgn(m_pwm) != sgn(m_tgt)) begin
                    if (iabs(m_pwm) <= STEP) begin
                        m_pwm = 0;
                        m_dwell_left = DWELL;
                    end else begin
                        m_pwm = m_pwm - sgn(m_pwm) * STEP;
                    end
                end else if (iabs(m_tgt - m_pwm) <= STEP) begin
                    m_pwm = m_tgt;
                end else begin
                    m_pwm = m_pwm + sgn(m_tgt - m_pwm) * STEP;
                end
            end
            m_phase = (m_phase + 1) % DIV;
        end
        if (v) begin
            m_tgt = clamp(c); m_idle = 0; m_to = 0;
        end else if (WD != 0 && m_idle == WD - 1) begin
            m_tgt = 0; m_to = 1;
        end else if (WD != 0) begin
            m_idle++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive, advance model, then compare all outputs 1ns after the edge.
    task automatic cycle(input bit r, input bit e, input bit v, input logic [8:0] c);
        rst = r; en = e; cmd_valid_i = v; cmd_i = c;
        @(posedge clk);
        if (r) model_reset();
        else if (e) model_step(v, sint(c));
        #1;
        check("model pwm", sint(pwm_o), m_pwm);
        check("model settled", int'(settled_o), int'(m_pwm == m_tgt && m_dwell_left == 0));
        check("model timeout", int'(timeout_o), int'(m_to));
    endtask

    task automatic wait_settled(input int bound, input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < bound && !ok; i++) begin
            cycle(0, 1, 0, 9'd0);
            if (settled_o) ok = 1;
        end
        check(name, int'(ok), 1);
    endtask

    typedef struct {
        bit         v;
        logic [8:0] cmd;
        int         pwm;
        bit         settled;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit v, input int cmd, input int n, input int pwm, input bit s);
        vec_t r;
        for (int i = 0; i < n; i++) begin
            r.v = v && (i == 0);
            r.cmd = 9'(cmd);
            r.pwm = pwm;
            r.settled = s;
            vecs.push_back(r);
        end
    endtask

    bit         ok;
    bit         s_at_zero;
    int         bad;
    bit         rr, re, rv;
    logic [8:0] rc;

    initial begin
        rst = 1; en = 1; cmd_valid_i = 0; cmd_i = '0;
        model_reset();

        // Ramp up to 100, then reverse to -50 through an 8-cycle dwell.
        add(1, 100, 3, 0, 0);
        add(0, 0, 4, 16, 0); add(0, 0, 4, 32, 0); add(0, 0, 4, 48, 0);
        add(0, 0, 4, 64, 0); add(0, 0, 4, 80, 0); add(0, 0, 4, 96, 0);
        add(0, 0, 1, 100, 1);
        add(1, -50, 3, 100, 0);
        add(0, 0, 4, 84, 0); add(0, 0, 4, 68, 0); add(0, 0, 4, 52, 0);
        add(0, 0, 4, 36, 0); add(0, 0, 4, 20, 0); add(0, 0, 4, 4, 0);
        add(0, 0, 12, 0, 0);
        add(0, 0, 4, -16, 0); add(0, 0, 4, -32, 0); add(0, 0, 4, -48, 0);
        add(0, 0, 4, -50, 1);

        @(negedge clk);
        cycle(1, 1, 0, 9'd0);
        check("reset pwm", sint(pwm_o), 0);
        check("reset settled", int'(settled_o), 1);
        check("reset timeout", int'(timeout_o), 0);

        foreach (vecs[i]) begin
            cycle(0, 1, vecs[i].v, vecs[i].cmd);
            check($sformatf("vec%0d pwm", i), sint(pwm_o), vecs[i].pwm);
            check($sformatf("vec%0d settled", i), int'(settled_o), int'(vecs[i].settled));
        end

        // Most negative code saturates to -255 and is never emitted; then swing to +255.
        cycle(1, 1, 0, 9'd0);
        cycle(0, 1, 1, 9'h100);
        bad = 0; ok = 0;
        for (int i = 0; i < 120 && !ok; i++) begin
            cycle(0, 1, 0, 9'd0);
            if (pwm_o == 9'h100) bad++;
            if (settled_o) ok = 1;
        end
        check("sat neg settled", int'(ok), 1);
        check("sat neg pwm", sint(pwm_o), -255);
        check("sat never 0x100", bad, 0);
        cycle(0, 1, 1, 9'h0FF);
        wait_settled(250, "sat pos settled");
        check("sat pos pwm", sint(pwm_o), 255);

        // Watchdog expiry ramps to zero without a dwell; a new command clears it.
        cycle(1, 1, 0, 9'd0);
        cycle(0, 1, 1, 9'd100);
        for (int i = 0; i < 999; i++) cycle(0, 1, 0, 9'd0);
        check("wd before expiry", int'(timeout_o), 0);
        check("wd pwm held", sint(pwm_o), 100);
        cycle(0, 1, 0, 9'd0);
        check("wd expired", int'(timeout_o), 1);
        ok = 0; s_at_zero = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            cycle(0, 1, 0, 9'd0);
            if (pwm_o == 9'd0) begin ok = 1; s_at_zero = settled_o; end
        end
        check("wd ramp to zero", int'(ok), 1);
        check("wd zero no dwell", int'(s_at_zero), 1);
        check("wd sticky", int'(timeout_o), 1);
        cycle(0, 1, 1, 9'd20);
        check("wd cleared", int'(timeout_o), 0);
        wait_settled(12, "wd recover settled");
        check("wd recover pwm", sint(pwm_o), 20);

        // Valid in the expiry cycle wins over the timeout.
        cycle(1, 1, 0, 9'd0);
        for (int i = 0; i < 999; i++) cycle(0, 1, 0, 9'd0);
        check("race pre", int'(timeout_o), 0);
        cycle(0, 1, 1, 9'(-40));
        check("race timeout", int'(timeout_o), 0);
        check("race settled", int'(settled_o), 0);
        cycle(0, 1, 0, 9'd0);
        check("race after", int'(timeout_o), 0);
        wait_settled(20, "race settled later");
        check("race pwm", sint(pwm_o), -40);

        // Clock-enable low freezes everything, including ignored strobes.
        cycle(1, 1, 0, 9'd0);
        cycle(0, 1, 1, 9'd200);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 9'd0);
        check("en pre pwm", sint(pwm_o), 16);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 1'($urandom), 9'($urandom));
            check("en frozen pwm", sint(pwm_o), 16);
            check("en frozen settled", int'(settled_o), 0);
        end
        cycle(0, 1, 0, 9'd0);
        check("en resume hold", sint(pwm_o), 16);
        cycle(0, 1, 0, 9'd0);
        check("en resume tick", sint(pwm_o), 32);

        // Reset in the middle of a dwell, with en low, returns to idle at once.
        cycle(1, 1, 0, 9'd0);
        cycle(0, 1, 1, 9'd30);
        wait_settled(20, "dwell setup settled");
        cycle(0, 1, 1, 9'(-30));
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            cycle(0, 1, 0, 9'd0);
            if (pwm_o == 9'd0) ok = 1;
        end
        check("dwell reached", int'(ok), 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 9'd0);
        check("in dwell settled", int'(settled_o), 0);
        cycle(1, 0, 0, 9'd0);
        check("rst dwell pwm", sint(pwm_o), 0);
        check("rst dwell settled", int'(settled_o), 1);
        check("rst dwell timeout", int'(timeout_o), 0);
        for (int i = 0; i < 12; i++) cycle(0, 1, 0, 9'd0);
        check("rst dwell stays 0", sint(pwm_o), 0);

        // Random traffic against the model.
        cycle(1, 1, 0, 9'd0);
        for (int i = 0; i < 4000; i++) begin
            rr = ($urandom_range(0, 799) == 0);
            re = ($urandom_range(0, 7) != 0);
            rv = ($urandom_range(0, 29) == 0);
            case ($urandom_range(0, 5))
                0: rc = 9'h100;
                1: rc = 9'h0FF;
                2: rc = 9'h101;
                default: rc = 9'($urandom);
            endcase
            cycle(rr, re, rv, rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
